// File: rtl/universal_shift_sequencer.sv
// N-bit universal shift register with a multi-step shift/rotate sequencer.
// Optional build macro USS_ARITH_SHIFT_EN enables mode 101 as arithmetic right shift.
module universal_shift_sequencer #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [N-1:0]  in_i,
    input  logic          start_i,
    input  logic [2:0]    mode_i,
    input  logic [CW-1:0] amt_i,
    input  logic          sin_i,
    output logic [N-1:0]  out_o,
    output logic          sout_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  out_q, out_d;
    logic          sout_q, sout_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;

    logic [N-1:0]  step_out;
    logic          step_sout;

    // One step of the latched mode; hold and reserved modes leave out/sout untouched.
    always_comb begin
        step_out  = out_q;
        step_sout = sout_q;
        case (mode_q)
            3'b001: begin
                step_out  = {sin_i, out_q[N-1:1]};
                step_sout = out_q[0];
            end
            3'b010: begin
                step_out  = {out_q[N-2:0], sin_i};
                step_sout = out_q[N-1];
            end
            3'b011: begin
                step_out  = {out_q[0], out_q[N-1:1]};
                step_sout = out_q[0];
            end
            3'b100: begin
                step_out  = {out_q[N-2:0], out_q[N-1]};
                step_sout = out_q[N-1];
            end
`ifdef USS_ARITH_SHIFT_EN
            3'b101: begin
                step_out  = {out_q[N-1], out_q[N-1:1]};
                step_sout = out_q[0];
            end
`else
            3'b101: begin
                step_out  = {sin_i, out_q[N-1:1]};
                step_sout = out_q[0];
            end
`endif
            default: begin
                step_out  = out_q;
                step_sout = sout_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    out_d = in_i;
                end else if (start_i) begin
                    mode_d = mode_i;
                    cnt_d  = amt_i;
                    if (amt_i != '0) begin
                        state_d = StShift;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StShift: begin
                out_d  = step_out;
                sout_d = step_sout;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            out_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign out_o  = out_q;
    assign sout_o = sout_q;
    assign busy_o = (state_q == StShift);
    assign done_o = done_q;

endmodule

// File: tb/tb_universal_shift_sequencer.sv
// Scoreboard bench for universal_shift_sequencer (N=8, CW=4).
module tb_universal_shift_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       load_i, start_i, sin_i;
    logic [7:0] in_i;
    logic [2:0] mode_i;
    logic [3:0] amt_i;
    logic [7:0] out_o;
    logic       sout_o, busy_o, done_o;

    universal_shift_sequencer #(.N(8), .CW(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load_i),
        .in_i    (in_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .amt_i   (amt_i),
        .sin_i   (sin_i),
        .out_o   (out_o),
        .sout_o  (sout_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] out;
        logic       sout;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic m_sout = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] din, input logic [2:0] m,
                          input logic [3:0] a, input logic s, input logic [7:0] eo,
                          input logic es, input bit interfere);
        exp_t e;
        int   edges;
        int   busy_cnt;
        bit   overlap;
        load_i = 1'b1;
        in_i   = din;
        tick();
        load_i = 1'b0;
        check_eq({tag, ":load"}, 32'(out_o), 32'(din));
        sb.push_back('{eo, es, int'(a) + 1});
        start_i = 1'b1;
        mode_i  = m;
        amt_i   = a;
        sin_i   = s;
        tick();
        start_i  = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        overlap  = 1'b0;
        while (!done_o && edges < int'(a) + 6) begin
            if (busy_o) busy_cnt++;
            if (interfere && edges == 1) begin
                load_i  = 1'b1;
                in_i    = 8'hFF;
                start_i = 1'b1;
                mode_i  = 3'b010;
                amt_i   = 4'd1;
            end
            tick();
            load_i  = 1'b0;
            start_i = 1'b0;
            edges++;
        end
        overlap = done_o & busy_o;
        e = sb.pop_front();
        if (!done_o) begin
            check_eq({tag, ":done_timeout"}, 32'(done_o), 32'd1);
        end else begin
            check_eq({tag, ":out"}, 32'(out_o), 32'(e.out));
            check_eq({tag, ":sout"}, 32'(sout_o), 32'(e.sout));
            check_eq({tag, ":latency"}, 32'(edges), 32'(e.lat));
            check_eq({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(a));
            check_eq({tag, ":busy_done_overlap"}, 32'(overlap), 32'd0);
        end
        tick();
        check_eq({tag, ":done_pulse_end"}, 32'(done_o), 32'd0);
        m_sout = es;
    endtask

    task automatic model(input logic [7:0] din, input logic [2:0] m, input logic [3:0] a,
                         input logic s, output logic [7:0] eo, output logic es);
        eo = din;
        es = m_sout;
        for (int i = 0; i < int'(a); i++) begin
            case (m)
                3'b001: begin es = eo[0]; eo = eo >> 1; eo[7] = s; end
                3'b010: begin es = eo[7]; eo = eo << 1; eo[0] = s; end
                3'b011: begin es = eo[0]; eo = {eo[0], eo[7:1]}; end
                3'b100: begin es = eo[7]; eo = {eo[6:0], eo[7]}; end
`ifdef USS_ARITH_SHIFT_EN
                3'b101: begin es = eo[0]; eo = {eo[7], eo[7:1]}; end
`else
                3'b101: begin es = eo[0]; eo = eo >> 1; eo[7] = s; end
`endif
                default: ;
            endcase
        end
    endtask

    initial begin
        int         done_seen;
        logic [7:0] din, eo;
        logic [2:0] m;
        logic [3:0] a;
        logic       s, es;

        rst_ni = 1'b0; load_i = 1'b0; start_i = 1'b0; sin_i = 1'b0;
        in_i = '0; mode_i = '0; amt_i = '0;
        #12;
        check_eq("rst:out", 32'(out_o), 32'd0);
        check_eq("rst:sout", 32'(sout_o), 32'd0);
        check_eq("rst:busy", 32'(busy_o), 32'd0);
        check_eq("rst:done", 32'(done_o), 32'd0);
        rst_ni = 1'b1;

        // Abort a shift mid-flight
        load_i = 1'b1; in_i = 8'hA5; tick(); load_i = 1'b0;
        start_i = 1'b1; mode_i = 3'b001; amt_i = 4'd5; tick(); start_i = 1'b0;
        tick(); tick();
        #2 rst_ni = 1'b0;
        #1;
        check_eq("abort:out", 32'(out_o), 32'd0);
        check_eq("abort:sout", 32'(sout_o), 32'd0);
        check_eq("abort:busy", 32'(busy_o), 32'd0);
        #3 rst_ni = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_o || busy_o) done_seen++;
        end
        check_eq("abort:no_done", 32'(done_seen), 32'd0);
        m_sout = 1'b0;

        run_op("lsr", 8'hA5, 3'b001, 4'd3, 1'b0, 8'h14, 1'b1, 1'b0);
        run_op("lsl", 8'h0F, 3'b010, 4'd4, 1'b1, 8'hFF, 1'b0, 1'b0);
        run_op("rol9", 8'h81, 3'b100, 4'd9, 1'b0, 8'h03, 1'b1, 1'b0);
`ifdef USS_ARITH_SHIFT_EN
        run_op("asr", 8'h90, 3'b101, 4'd2, 1'b0, 8'hE4, 1'b0, 1'b0);
`else
        run_op("asr", 8'h90, 3'b101, 4'd2, 1'b0, 8'h24, 1'b0, 1'b0);
`endif

        // load wins over start
        load_i = 1'b1; start_i = 1'b1; in_i = 8'h3C; mode_i = 3'b001; amt_i = 4'd3;
        tick();
        load_i = 1'b0; start_i = 1'b0;
        check_eq("ldst:out", 32'(out_o), 32'h3C);
        check_eq("ldst:busy", 32'(busy_o), 32'd0);
        tick();
        check_eq("ldst:busy2", 32'(busy_o), 32'd0);
        check_eq("ldst:out2", 32'(out_o), 32'h3C);

        run_op("amt0", 8'h5A, 3'b001, 4'd0, 1'b0, 8'h5A, m_sout, 1'b0);
        run_op("ignore", 8'hA5, 3'b011, 4'd4, 1'b0, 8'h5A, 1'b0, 1'b1);
        run_op("hold", 8'hC3, 3'b000, 4'd3, 1'b1, 8'hC3, m_sout, 1'b0);

        for (int i = 0; i < 6; i++) begin
            din = 8'($urandom);
            m   = 3'($urandom_range(0, 7));
            a   = 4'($urandom_range(0, 15));
            s   = 1'($urandom);
            model(din, m, a, s, eo, es);
            run_op("rand", din, m, a, s, eo, es, 1'b0);
        end

        // Start accepted in the done cycle
        load_i = 1'b1; in_i = 8'h01; tick(); load_i = 1'b0;
        start_i = 1'b1; mode_i = 3'b011; amt_i = 4'd1; tick(); start_i = 1'b0;
        tick();
        check_eq("b2b:done1", 32'(done_o), 32'd1);
        check_eq("b2b:out1", 32'(out_o), 32'h80);
        start_i = 1'b1; tick(); start_i = 1'b0;
        check_eq("b2b:busy2", 32'(busy_o), 32'd1);
        tick();
        check_eq("b2b:done2", 32'(done_o), 32'd1);
        check_eq("b2b:out2", 32'(out_o), 32'h40);
        check_eq("b2b:sout2", 32'(sout_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_sequencer.md
# universal_shift_sequencer

Parametrised N-bit universal shift register with a multi-step shift sequencer. A parallel load writes the register. A start command with a shift amount and mode then shifts, rotates or arithmetic-shifts it one position per clock until the amount is exhausted, and signals completion with a done pulse. It supersedes the fixed left/right shift register as the general shifting element for datapath and serial-conversion use.

## Interface
- N, default 8: register width in bits (N ≥ 2)
- CW, default 4: width of the shift-amount input; amounts 0 to 2^CW−1
- clk, input, 1: single clock; all state changes on the rising edge
- reset, input, 1: asynchronous, active-low reset
- load, input, 1: parallel-load strobe
- in, input, N: parallel-load data
- start, input, 1: begin a shift operation
- mode, input, 3: shift mode, latched at start
- amt, input, CW: number of single-bit steps, latched at start
- sin, input, 1: serial fill bit for logical shifts, sampled live on every step
- out, output, N: register contents
- sout, output, 1: bit most recently shifted or rotated out
- busy, output, 1: high while steps are in progress
- done, output, 1: one-cycle completion pulse

## Operation
- States:
  - IDLE: accepts commands.
  - SHIFT: performs steps.
- IDLE priority:
  - load wins over start; with load=1, out<=in and start is ignored.
  - start=1 with load=0 latches mode and amt.
  - If amt≠0, go to SHIFT.
  - If amt=0, stay in IDLE and pulse done.
- SHIFT:
  - Each edge performs one step and decrements the remaining count.
  - The edge performing the final step returns the block to IDLE and pulses done.
- While busy=1, load and start are ignored and no queueing occurs.
- Modes (one step):
  - 000 hold: out unchanged and sout unchanged; steps are still counted.
  - 001 logical right: out<={sin,out[N-1:1]}, sout<=out[0].
  - 010 logical left: out<={out[N-2:0],sin}, sout<=out[N-1].
  - 011 rotate right: out<={out[0],out[N-1:1]}, sout<=out[0].
  - 100 rotate left: out<={out[N-2:0],out[N-1]}, sout<=out[N-1].
  - 101 arithmetic right: out<={out[N-1],out[N-1:1]}, sout<=out[0]. Subject to the configuration macro.
  - 110 and 111 reserved: behave as hold.
- Amounts greater than N are legal. Each step is executed literally, so a rotate by N+1 equals a rotate by 1.
- sout changes only on a step that moves data, or on reset. load does not change sout.

## Timing
- Reset (reset=0, asynchronous) forces:
  - out=0, sout=0, busy=0, done=0, state=IDLE.
  - Any remaining count is cleared.
- Reset during SHIFT aborts the operation; no done pulse is produced afterwards.
- load sampled at edge k: out=in after edge k.
- start sampled at edge k with amt=A>0:
  - busy=1 after edge k.
  - Steps occur on edges k+1 through k+A.
  - After edge k+A: busy=0 and done=1.
  - After edge k+A+1: done=0.
  - Total latency from start to done is A+1 edges.
- start at edge k with amt=0: done=1 for one cycle after edge k; busy stays 0; out unchanged.
- Back-to-back operation: a start sampled in the cycle where done=1 is accepted, because the state is already IDLE.
- done and busy are never high simultaneously.

## Configuration
- Macro: USS_ARITH_SHIFT_EN.
- Defined: mode 101 performs an arithmetic right shift with sign replication, as specified above.
- Undefined:
  - Mode 101 behaves exactly as mode 001, logical right with sin fill.
  - No sign-replication logic is synthesised.
- All other modes are identical in both builds.

## Test plan
All scenarios use N=8 and CW=4.
- Reset abort: load 8'hA5, start mode 001 amt 5, then drive reset=0 after 2 steps. Expect out=0, sout=0, busy=0, and no done pulse after reset is released.
- Logical right: load 8'hA5, start mode 001 amt 3 with sin=0. Expect out=8'h14, sout=1, done high exactly 4 edges after start, busy high for 3 cycles.
- Logical left with fill: load 8'h0F, start mode 010 amt 4 with sin=1. Expect out=8'hFF, sout=0.
- Rotate wrap: load 8'h81, start mode 100 amt 9. Expect out=8'h03, sout=1, done 10 edges after start.
- Arithmetic right: load 8'h90, start mode 101 amt 2 with sin=0.
  - With USS_ARITH_SHIFT_EN defined: out=8'hE4.
  - Without it: out=8'h24.
- Command rules:
  - load and start asserted together with in=8'h3C: out=8'h3C and no operation starts.
  - start with amt=0: done pulses on the next cycle, out unchanged.
  - load=1 with in=8'hFF and start=1 during busy: both ignored and the final result is unaffected.
